// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Writer side of the instruction memory. Takes a program as a
//                little-endian byte stream over a valid/ready handshake. It
//                packs every four bytes into a 32-bit word and issues one
//                single-cycle write per word. The processor is held in reset
//                until the requested number of words has been written.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              system clock, rising edge
//    reset            synchronous active-high reset
//    start_i          single-cycle load request (honoured in IDLE/DONE only)
//    num_words_i      words to load, latched on an accepted start
//    in_valid_i       byte source has in_data_i valid
//    in_data_i        program byte, little-endian within a word
//    in_ready_o       loader accepts a byte this cycle
//    we_o             instruction memory write enable, one pulse per word
//    wa_o             word-aligned byte address of the write
//    wd_o             assembled instruction word
//    busy_o           load in progress (RECV or WRITE)
//    done_o           load complete, held until next accepted start/reset
//    err_o            last start had an illegal num_words_i
//    cpu_reset_o      processor reset hold, low only in DONE
//    words_written_o  words written in the current/last load
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_words_i,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    output logic             in_ready_o,
    output logic             we_o,
    output logic [31:0]      wa_o,
    output logic [31:0]      wd_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             cpu_reset_o,
    output logic [CNT_W-1:0] words_written_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    logic [1:0]       byte_cnt_q;
    logic [CNT_W-1:0] num_words_q;
    logic [CNT_W-1:0] words_written_q;
    logic [31:0]      wa_q;
    logic [31:0]      wd_q;
    logic             in_ready_q;
    logic             we_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic             cpu_reset_q;

    logic             w_start_legal;
    logic             w_byte_fire;
    logic [CNT_W-1:0] words_written_d;

    assign w_start_legal   = (num_words_i != '0) && (num_words_i <= CNT_W'(DEPTH));
    assign w_byte_fire     = in_valid_i & in_ready_q;
    assign words_written_d = words_written_q + CNT_W'(1);

    // All outputs are registered and updated together with the state so
    // they always reflect the state the FSM is in during the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            byte_cnt_q      <= 2'd0;
            num_words_q     <= '0;
            words_written_q <= '0;
            wa_q            <= 32'd0;
            wd_q            <= 32'd0;
            in_ready_q      <= 1'b0;
            we_q            <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
            cpu_reset_q     <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        done_q      <= 1'b0;
                        cpu_reset_q <= 1'b1;
                        if (w_start_legal) begin
                            num_words_q     <= num_words_i;
                            words_written_q <= '0;
                            byte_cnt_q      <= 2'd0;
                            wa_q            <= 32'd0;
                            err_q           <= 1'b0;
                            busy_q          <= 1'b1;
                            in_ready_q      <= 1'b1;
                            state_q         <= S_RECV;
                        end else begin
                            // Illegal size: flag it and park in IDLE with
                            // the processor still held in reset.
                            err_q   <= 1'b1;
                            state_q <= S_IDLE;
                        end
                    end
                end

                S_RECV: begin
                    if (w_byte_fire) begin
                        wd_q[{byte_cnt_q, 3'b000} +: 8] <= in_data_i;
                        byte_cnt_q                      <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            in_ready_q <= 1'b0;
                            we_q       <= 1'b1;
                            state_q    <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    we_q            <= 1'b0;
                    words_written_q <= words_written_d;
                    wa_q            <= wa_q + 32'd4;
                    byte_cnt_q      <= 2'd0;
                    if (words_written_d == num_words_q) begin
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cpu_reset_q <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_RECV;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o      = in_ready_q;
    assign we_o            = we_q;
    assign wa_o            = wa_q;
    assign wd_o            = wd_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign err_o           = err_q;
    assign cpu_reset_o     = cpu_reset_q;
    assign words_written_o = words_written_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Directed self-checking bench for imem_loader. Writes seen on
//                the memory port are captured into queues and compared with
//                hand-computed words and addresses.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_words = '0;
    logic             in_valid = 1'b0;
    logic [7:0]       in_data = 8'd0;
    logic             in_ready;
    logic             we;
    logic [31:0]      wa;
    logic [31:0]      wd;
    logic             busy;
    logic             done;
    logic             err;
    logic             cpu_reset;
    logic [CNT_W-1:0] words_written;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mon_wa[$];
    logic [31:0] mon_wd[$];
    int          mon_cyc[$];

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start),
        .num_words_i     (num_words),
        .in_valid_i      (in_valid),
        .in_data_i       (in_data),
        .in_ready_o      (in_ready),
        .we_o            (we),
        .wa_o            (wa),
        .wd_o            (wd),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .cpu_reset_o     (cpu_reset),
        .words_written_o (words_written)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write pulse on the memory port.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            mon_wa.push_back(wa);
            mon_wd.push_back(wd);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_wa.delete();
        mon_wd.delete();
        mon_cyc.delete();
    endtask

    task automatic do_start(input int n);
        start     = 1'b1;
        num_words = CNT_W'(n);
        tick();
        start     = 1'b0;
    endtask

    // Presents one byte and waits (bounded) until it is accepted.
    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 50; i++) begin
            if (in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({in_ready, we, busy, done, err, cpu_reset} !== 6'b000001) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000001", {in_ready, we, busy, done, err, cpu_reset});
        end
        checks++;
        if ({wa, wd} !== 64'd0) begin
            errors++;
            $display("FAIL reset_wa_wd: got %h/%h expected 0/0", wa, wd);
        end
        checks++;
        if (words_written !== 7'd0) begin
            errors++;
            $display("FAIL reset_words_written: got %0d expected 0", words_written);
        end
    endtask

    task automatic test_basic_load();
        logic [7:0] bytes [8] = '{8'h0F, 8'h00, 8'h4F, 8'hE0, 8'h04, 8'h10, 8'h80, 8'hE2};
        bit ok, all_ok;
        int c0;
        clear_mon();
        do_start(2);
        checks++;
        if ({busy, in_ready, cpu_reset, done} !== 4'b1110) begin
            errors++;
            $display("FAIL basic_start_flags: got %b expected 1110", {busy, in_ready, cpu_reset, done});
        end
        c0 = cyc;
        all_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i], ok);
            all_ok &= ok;
        end
        wait_done(ok);
        checks++;
        if (!(all_ok && ok)) begin
            errors++;
            $display("FAIL basic_handshake: got accepted=%0b done=%0b expected 1/1", all_ok, ok);
        end
        checks++;
        if (mon_wa.size() != 2) begin
            errors++;
            $display("FAIL basic_write_count: got %0d expected 2", mon_wa.size());
        end else begin
            checks++;
            if ({mon_wa[0], mon_wd[0]} !== {32'h0, 32'hE04F000F}) begin
                errors++;
                $display("FAIL basic_write0: got %h/%h expected 00000000/e04f000f", mon_wa[0], mon_wd[0]);
            end
            checks++;
            if ({mon_wa[1], mon_wd[1]} !== {32'h4, 32'hE2801004}) begin
                errors++;
                $display("FAIL basic_write1: got %h/%h expected 00000004/e2801004", mon_wa[1], mon_wd[1]);
            end
            // First byte is presented in cycle c0; the write pulse lands in
            // the fifth cycle of the word, i.e. four cycles later.
            checks++;
            if (mon_cyc[0] - c0 != 4) begin
                errors++;
                $display("FAIL basic_latency: got %0d expected 4", mon_cyc[0] - c0);
            end
            checks++;
            if (mon_cyc[1] - mon_cyc[0] != 5) begin
                errors++;
                $display("FAIL basic_throughput: got %0d expected 5", mon_cyc[1] - mon_cyc[0]);
            end
        end
        checks++;
        if ({done, cpu_reset, busy, words_written} !== {3'b100, 7'd2}) begin
            errors++;
            $display("FAIL basic_final: got %b/%0d expected 100/2", {done, cpu_reset, busy}, words_written);
        end
    endtask

    task automatic test_gapped_load();
        logic [7:0] bytes [8] = '{8'h0F, 8'h00, 8'h4F, 8'hE0, 8'h04, 8'h10, 8'h80, 8'hE2};
        bit ok, all_ok, gap_ready_ok, early_we_ok;
        clear_mon();
        do_start(2);
        all_ok = 1'b1;
        gap_ready_ok = 1'b1;
        early_we_ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (3) begin
                tick();
                if ((i % 4) != 0 && in_ready !== 1'b1) gap_ready_ok = 1'b0;
            end
            if (i == 3 && mon_wa.size() != 0) early_we_ok = 1'b0;
            if (i == 7 && mon_wa.size() != 1) early_we_ok = 1'b0;
            send_byte(bytes[i], ok);
            all_ok &= ok;
        end
        wait_done(ok);
        checks++;
        if (!(all_ok && ok)) begin
            errors++;
            $display("FAIL gap_handshake: got accepted=%0b done=%0b expected 1/1", all_ok, ok);
        end
        checks++;
        if (!gap_ready_ok) begin
            errors++;
            $display("FAIL gap_in_ready: got in_ready low in RECV gap, expected 1");
        end
        checks++;
        if (!early_we_ok) begin
            errors++;
            $display("FAIL gap_early_we: got write before 4th byte, expected none");
        end
        checks++;
        if (mon_wa.size() != 2) begin
            errors++;
            $display("FAIL gap_write_count: got %0d expected 2", mon_wa.size());
        end else begin
            checks++;
            if ({mon_wa[0], mon_wd[0], mon_wa[1], mon_wd[1]} !== {32'h0, 32'hE04F000F, 32'h4, 32'hE2801004}) begin
                errors++;
                $display("FAIL gap_writes: got %h/%h %h/%h expected 0/e04f000f 4/e2801004",
                         mon_wa[0], mon_wd[0], mon_wa[1], mon_wd[1]);
            end
        end
    endtask

    task automatic test_illegal_size();
        bit ok, all_ok;
        logic [7:0] bytes [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        clear_mon();
        do_start(0);
        checks++;
        if ({err, done, busy, cpu_reset, in_ready} !== 5'b10010) begin
            errors++;
            $display("FAIL err_zero: got %b expected 10010", {err, done, busy, cpu_reset, in_ready});
        end
        repeat (3) tick();
        checks++;
        if (mon_wa.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL err_idle: got writes=%0d busy=%b expected 0/0", mon_wa.size(), busy);
        end
        do_start(65);
        checks++;
        if ({err, busy, cpu_reset} !== 3'b101) begin
            errors++;
            $display("FAIL err_65: got %b expected 101", {err, busy, cpu_reset});
        end
        do_start(1);
        checks++;
        if ({err, busy} !== 2'b01) begin
            errors++;
            $display("FAIL err_clear: got %b expected 01", {err, busy});
        end
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], ok);
            all_ok &= ok;
        end
        wait_done(ok);
        checks++;
        if (!(all_ok && ok) || mon_wa.size() != 1) begin
            errors++;
            $display("FAIL err_reload: got accepted=%0b done=%0b writes=%0d expected 1/1/1", all_ok, ok, mon_wa.size());
        end else begin
            checks++;
            if ({mon_wa[0], mon_wd[0]} !== {32'h0, 32'hDDCCBBAA}) begin
                errors++;
                $display("FAIL err_reload_word: got %h/%h expected 0/ddccbbaa", mon_wa[0], mon_wd[0]);
            end
        end
    endtask

    task automatic test_start_midload();
        bit ok, all_ok;
        clear_mon();
        do_start(3);
        all_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h10 + i), ok);
            all_ok &= ok;
        end
        start = 1'b1;
        num_words = 7'd1;
        tick();
        start = 1'b0;
        checks++;
        if ({busy, err, done} !== 3'b100) begin
            errors++;
            $display("FAIL mid_start_ignored: got %b expected 100", {busy, err, done});
        end
        for (int i = 6; i < 12; i++) begin
            send_byte(8'(8'h10 + i), ok);
            all_ok &= ok;
        end
        wait_done(ok);
        checks++;
        if (!(all_ok && ok) || mon_wa.size() != 3) begin
            errors++;
            $display("FAIL mid_count: got accepted=%0b done=%0b writes=%0d expected 1/1/3", all_ok, ok, mon_wa.size());
        end else begin
            checks++;
            if ({mon_wa[0], mon_wa[1], mon_wa[2]} !== {32'h0, 32'h4, 32'h8}) begin
                errors++;
                $display("FAIL mid_addr: got %h %h %h expected 0 4 8", mon_wa[0], mon_wa[1], mon_wa[2]);
            end
            checks++;
            if ({mon_wd[0], mon_wd[1], mon_wd[2]} !== {32'h13121110, 32'h17161514, 32'h1B1A1918}) begin
                errors++;
                $display("FAIL mid_data: got %h %h %h expected 13121110 17161514 1b1a1918",
                         mon_wd[0], mon_wd[1], mon_wd[2]);
            end
        end
        checks++;
        if (words_written !== 7'd3) begin
            errors++;
            $display("FAIL mid_words_written: got %0d expected 3", words_written);
        end
    endtask

    task automatic test_reset_midload();
        bit ok, all_ok;
        clear_mon();
        do_start(2);
        for (int i = 0; i < 6; i++) begin
            send_byte(8'(8'h50 + i), ok);
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({in_ready, we, busy, done, err, cpu_reset} !== 6'b000001) begin
            errors++;
            $display("FAIL midreset_flags: got %b expected 000001", {in_ready, we, busy, done, err, cpu_reset});
        end
        checks++;
        if ({wa, wd, words_written} !== {32'd0, 32'd0, 7'd0}) begin
            errors++;
            $display("FAIL midreset_regs: got %h/%h/%0d expected 0/0/0", wa, wd, words_written);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (mon_wa.size() != 1) begin
            errors++;
            $display("FAIL midreset_prior_writes: got %0d expected 1", mon_wa.size());
        end
        clear_mon();
        do_start(1);
        all_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'(8'h60 + i), ok);
            all_ok &= ok;
        end
        wait_done(ok);
        checks++;
        if (!(all_ok && ok) || mon_wa.size() != 1) begin
            errors++;
            $display("FAIL midreset_reload: got accepted=%0b done=%0b writes=%0d expected 1/1/1", all_ok, ok, mon_wa.size());
        end else begin
            checks++;
            if ({mon_wa[0], mon_wd[0]} !== {32'h0, 32'h63626160}) begin
                errors++;
                $display("FAIL midreset_word: got %h/%h expected 0/63626160", mon_wa[0], mon_wd[0]);
            end
        end
    endtask

    task automatic test_full_depth();
        bit ok, all_ok, data_ok;
        logic [31:0] exp_wd;
        clear_mon();
        do_start(DEPTH);
        all_ok = 1'b1;
        for (int i = 0; i < DEPTH * 4; i++) begin
            send_byte(8'(i), ok);
            all_ok &= ok;
        end
        wait_done(ok);
        checks++;
        if (!(all_ok && ok) || mon_wa.size() != DEPTH) begin
            errors++;
            $display("FAIL full_count: got accepted=%0b done=%0b writes=%0d expected 1/1/64", all_ok, ok, mon_wa.size());
        end else begin
            checks++;
            if ({mon_wa[63], mon_wd[63]} !== {32'hFC, 32'hFFFEFDFC}) begin
                errors++;
                $display("FAIL full_last: got %h/%h expected 000000fc/fffefdfc", mon_wa[63], mon_wd[63]);
            end
            data_ok = 1'b1;
            for (int k = 0; k < DEPTH; k++) begin
                exp_wd = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
                if (mon_wa[k] !== 32'(4*k) || mon_wd[k] !== exp_wd) data_ok = 1'b0;
            end
            checks++;
            if (!data_ok) begin
                errors++;
                $display("FAIL full_all_words: got at least one wrong address/word, expected byte-index pattern");
            end
        end
        checks++;
        if ({done, cpu_reset, words_written} !== {2'b10, 7'd64}) begin
            errors++;
            $display("FAIL full_final: got %b/%0d expected 10/64", {done, cpu_reset}, words_written);
        end
        do_start(1);
        checks++;
        if ({busy, done, cpu_reset, words_written, wa} !== {3'b101, 7'd0, 32'd0}) begin
            errors++;
            $display("FAIL full_restart: got %b/%0d/%h expected 101/0/0", {busy, done, cpu_reset}, words_written, wa);
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hC0 + 8'(i), ok);
        end
        wait_done(ok);
        checks++;
        if (mon_wa.size() != DEPTH + 1 || !ok) begin
            errors++;
            $display("FAIL full_reload_count: got %0d done=%0b expected 65/1", mon_wa.size(), ok);
        end else begin
            checks++;
            if ({mon_wa[64], mon_wd[64]} !== {32'h0, 32'hC3C2C1C0}) begin
                errors++;
                $display("FAIL full_reload_word: got %h/%h expected 0/c3c2c1c0", mon_wa[64], mon_wd[64]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_illegal_size();
        test_start_midload();
        test_reset_midload();
        test_full_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
